// File: rtl/mips_multicycle_core_if.sv
// mips_multicycle_core_if
//   Shared instruction/data memory port of the multi-cycle MIPS core.
//   A transfer completes on the rising edge where mem_req=1 and mem_ready=1.
//   Ports (master = core, slave = memory):
//     mem_req    master->slave  request valid, held stable until completion
//     mem_we     master->slave  1 = store, 0 = load/fetch
//     mem_addr   master->slave  word-aligned byte address (ADDR_W bits)
//     mem_wdata  master->slave  store data
//     mem_rdata  slave->master  read data, valid while mem_ready=1
//     mem_ready  slave->master  completes the pending request
interface mips_multicycle_core_if #(
   parameter int ADDR_W = 12
) ();
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
//   Multi-cycle MIPS-I integer core (FETCH/DECODE/EXEC/MEM/WB) sharing one
//   memory port for instructions and data, tolerant of wait-state memories.
//   Subset: addu subu and or slt, lw sw beq ori addiu lui, and optionally j.
//   Build option: define MIPS_JUMP_EN to execute j (opcode 6'h02); otherwise
//   j is treated as an unsupported instruction (illegal pulse, NOP).
//   Ports:
//     CLK      clock, rising edge
//     RST      synchronous active-high reset
//     mem      memory port (master side of mips_multicycle_core_if)
//     retire   one-cycle pulse when an instruction completes
//     pc_dbg   PC of the instruction in flight
//     illegal  one-cycle pulse for an unsupported opcode/funct
module mips_multicycle_core #(
   parameter int                ADDR_W   = 12,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                   CLK,
   input  logic                   RST,
   mips_multicycle_core_if.master mem,
   output logic                   retire,
   output logic [ADDR_W-1:0]      pc_dbg,
   output logic                   illegal
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2a;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
   } state_t;

   // control state (reset)
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       gpr_q [32];

   // datapath registers (no reset needed)
   logic [31:0]       ir_q, ir_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic [ADDR_W-1:0] bt_q, bt_d;
   logic [31:0]       alu_q, alu_d;
   logic [31:0]       mdr_q, mdr_d;

   // register-file write port
   logic              wr_en;
   logic [4:0]        wr_idx;
   logic [31:0]       wr_data;

   // instruction fields
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [31:0] sext_imm, zext_imm;

   assign op       = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign imm      = ir_q[15:0];
   assign sext_imm = {{16{imm[15]}}, imm};
   assign zext_imm = {16'h0, imm};

`ifdef MIPS_JUMP_EN
   // Target keeps the top PC nibble; for narrow PCs those bits are zero.
   logic [31:0]       jmp_full;
   logic [ADDR_W-1:0] jmp_pc;
   assign jmp_full = {32'(pc_q) >> 28, ir_q[25:0], 2'b00} & 32'hffff_ffff;
   assign jmp_pc   = jmp_full[ADDR_W-1:0];
`endif

   // ALU result and instruction legality, evaluated from IR/A/B in EXEC
   logic [31:0] alu_res;
   logic        op_ok;

   always_comb begin
      alu_res = '0;
      op_ok   = 1'b0;
      case (op)
         OP_RTYPE: begin
            op_ok = 1'b1;
            case (funct)
               FN_ADDU: alu_res = a_q + b_q;
               FN_SUBU: alu_res = a_q - b_q;
               FN_AND:  alu_res = a_q & b_q;
               FN_OR:   alu_res = a_q | b_q;
               FN_SLT:  alu_res = {31'b0, ($signed(a_q) < $signed(b_q))};
               default: op_ok = 1'b0;
            endcase
         end
         OP_ADDIU, OP_LW, OP_SW: begin
            op_ok   = 1'b1;
            alu_res = a_q + sext_imm;
         end
         OP_ORI: begin
            op_ok   = 1'b1;
            alu_res = a_q | zext_imm;
         end
         OP_LUI: begin
            op_ok   = 1'b1;
            alu_res = {imm, 16'h0};
         end
         OP_BEQ: op_ok = 1'b1;
`ifdef MIPS_JUMP_EN
         OP_J:   op_ok = 1'b1;
`endif
         default: op_ok = 1'b0;
      endcase
   end

   logic [ADDR_W-1:0] next_pc;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ipc_d   = ipc_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      bt_d    = bt_q;
      alu_d   = alu_q;
      mdr_d   = mdr_q;
      wr_en   = 1'b0;
      wr_idx  = rt;
      wr_data = alu_q;
      retire  = 1'b0;
      illegal = 1'b0;
      next_pc = pc_q;

      case (state_q)
         // ---- FETCH: raise the request if not already up, wait for ready
         S_FETCH: begin
            if (!req_q) begin
               req_d  = 1'b1;
               we_d   = 1'b0;
               addr_d = pc_q;
            end else if (mem.mem_ready) begin
               req_d   = 1'b0;
               ir_d    = mem.mem_rdata;
               ipc_d   = pc_q;
               pc_d    = pc_q + ADDR_W'(4);
               state_d = S_DECODE;
            end
         end
         // ---- DECODE: operand read and branch target (PC already +4)
         S_DECODE: begin
            a_d     = gpr_q[rs];
            b_d     = gpr_q[rt];
            bt_d    = pc_q + ADDR_W'(sext_imm << 2);
            state_d = S_EXEC;
         end
         // ---- EXEC: a request issued here completes in the first cycle
         //      of the next state when the memory has no wait states
         S_EXEC: begin
            alu_d = alu_res;
            if (!op_ok) begin
               illegal = 1'b1;
               state_d = S_FETCH;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = pc_q;
            end else if (op == OP_BEQ) begin
               next_pc = (a_q == b_q) ? bt_q : pc_q;
               retire  = 1'b1;
               pc_d    = next_pc;
               state_d = S_FETCH;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = next_pc;
`ifdef MIPS_JUMP_EN
            end else if (op == OP_J) begin
               retire  = 1'b1;
               pc_d    = jmp_pc;
               state_d = S_FETCH;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = jmp_pc;
`endif
            end else if (op == OP_LW || op == OP_SW) begin
               state_d = S_MEM;
               req_d   = 1'b1;
               we_d    = (op == OP_SW);
               addr_d  = {alu_res[ADDR_W-1:2], 2'b00};
               if (op == OP_SW) begin
                  wdata_d = b_q;
               end
            end else begin
               state_d = S_WB;
            end
         end
         // ---- MEM: store retires on completion, load moves on to WB.
         //      The request always drops for a cycle after completion.
         S_MEM: begin
            if (req_q && mem.mem_ready) begin
               req_d = 1'b0;
               we_d  = 1'b0;
               if (we_q) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  mdr_d   = mem.mem_rdata;
                  state_d = S_WB;
               end
            end
         end
         // ---- WB: register write and retire, fetch of the next PC issued
         S_WB: begin
            wr_idx  = (op == OP_RTYPE) ? rd : rt;
            wr_data = (op == OP_LW) ? mdr_q : alu_q;
            wr_en   = (wr_idx != 5'd0);
            retire  = 1'b1;
            state_d = S_FETCH;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = pc_q;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ipc_q   <= RESET_PC;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= RESET_PC;
         wdata_q <= '0;
         for (int i = 0; i < 32; i++) begin
            gpr_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ipc_q   <= ipc_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         if (wr_en) begin
            gpr_q[wr_idx] <= wr_data;
         end
      end
   end

   always_ff @(posedge CLK) begin
      ir_q  <= ir_d;
      a_q   <= a_d;
      b_q   <= b_d;
      bt_q  <= bt_d;
      alu_q <= alu_d;
      mdr_q <= mdr_d;
   end

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign pc_dbg        = (state_q == S_FETCH) ? pc_q : ipc_q;

endmodule
